// File: rtl/add_sub_serial_pkg.sv
// Shared constants, state encoding and flag helpers for the nibble-serial add/sub stage.
package add_sub_serial_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands share a sign that the sum does not.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_sub_serial_nibble_adder.sv
// One 4-bit adder slice with carry in/out; the serial stage reuses it once per nibble.
module nibble_adder
    import add_sub_serial_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};

endmodule

// File: rtl/add_sub_serial.sv
// Nibble-serial add/subtract: captures a WIDTH-bit operand pair, runs it through one
// 4-bit slice over NIBBLES cycles, and holds the result and flags until consumed.
module add_sub_serial
    import add_sub_serial_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int WIDTH = NIB_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   res_sh_r;
    logic               c_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [NIB_W-1:0]       r4_s;
    logic                   c_next_s;
    logic                   last_s;
    logic [WIDTH+NIB_W-1:0] res_cat_s;
    logic [WIDTH-1:0]       res_next_s;

    nibble_adder u_slice (
        .a  (a_sh_r[NIB_W-1:0]),
        .b  (b_sh_r[NIB_W-1:0]),
        .ci (c_r),
        .s  (r4_s),
        .co (c_next_s)
    );

    assign last_s = (cnt_r == CNT_W'(NIBBLES - 1));

    // New slice enters at the top so the least significant nibble ends at bit 0.
    always_comb begin
        res_cat_s  = {r4_s, res_sh_r};
        res_next_s = res_cat_s[WIDTH+NIB_W-1:NIB_W];
    end

    // Next-state decode for the accept / compute / hand-off sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, handshake outputs, operand shifters and the result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh_r    <= '0;
            b_sh_r    <= '0;
            res_sh_r  <= '0;
            c_r       <= 1'b0;
            cnt_r     <= '0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else begin
            state_r   <= state_s;
            in_ready  <= (state_s == IDLE);
            out_valid <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r   <= op_a;
                        b_sh_r   <= op_b ^ {WIDTH{sub}};
                        c_r      <= sub;
                        cnt_r    <= '0;
                        res_sh_r <= '0;
                    end
                end
                CALC: begin
                    a_sh_r   <= a_sh_r >> NIB_W;
                    b_sh_r   <= b_sh_r >> NIB_W;
                    res_sh_r <= res_next_s;
                    c_r      <= c_next_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        result <= res_next_s;
                        cout   <= c_next_s;
                        ovf    <= ovf_calc(a_sh_r[NIB_W-1], b_sh_r[NIB_W-1], r4_s[NIB_W-1]);
                        zero   <= (res_next_s == '0);
                        neg    <= res_next_s[WIDTH-1];
                        cnt_r  <= '0;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
